zx_scandoubler: RTL and testbench
=================================

Name: zx_scandoubler

Overview:
- Converts the 15.6 kHz PAL-timed ULA pixel stream into a 31.2 kHz line-doubled stream for VGA output. It sits directly downstream of the video generator and consumes its 9-bit RGB and its sync.
- Runs on one 14 MHz clock. Input pixels arrive on a 7 MHz clock enable.
- Each input line is written into one bank of a two-line buffer. The previous line is read out twice, at double speed, from the other bank.
- Generates its own output hsync and re-times vsync to output line boundaries.

Parameters:
- DEPTH, 512, entries per line-buffer bank; also bounds the write address (9 bits).
- LINE_DEFAULT, 448, line length (input pixels) used after reset until the first valid measurement.
- LINE_MIN, 64, shortest measured line accepted as valid.
- HS_WIDTH, 54, output hsync pulse width in clocks.

Ports:
- clock  in  1  14 MHz system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  input pixel enable, high one clock in two (7 MHz).
- rgbIn  in  9  input pixel {r[2:0],g[2:0],b[2:0]}, valid when ce=1.
- hsIn  in  1  input horizontal sync, active low, sampled on ce.
- vsIn  in  1  input vertical sync, active low, sampled on ce.
- scanlines  in  1  1 = dim the second output copy of each line.
- rgbOut  out  9  output pixel, registered.
- hsOut  out  1  output hsync, active low, registered.
- vsOut  out  1  output vsync, active low, registered.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - rgbOut=0, hsOut=1, vsOut=1.
  - wrAddr=0, rdAddr=0, bank=0, pass=0, lineLen=LINE_DEFAULT, hsPrev=1.
  - Buffer contents are undefined.
  - Release is synchronous to clock.
  - Reset mid-line discards both buffered lines; output is black until the next input hsync edge.
- **Input edge detect:** on ce=1, hsPrev<=hsIn. hsFall = ce & hsPrev & ~hsIn.
- **Write side (advances only on ce=1):**
  - Ordinary pixel: buffer[bank][wrAddr]<=rgbIn; wrAddr<=wrAddr+1.
  - wrAddr saturates at DEPTH-1; it never wraps, and further writes overwrite the last entry.
  - On hsFall:
    - wrAddr<=0 and bank<=~bank.
    - If wrAddr>=LINE_MIN, lineLen<=wrAddr; otherwise lineLen is unchanged (glitch reject).
    - The pixel present on the hsFall cycle is written at address 0 of the new bank.
- **Read side (every clock, from bank ~bank):**
  - rdAddr increments every clock.
  - When rdAddr==lineLen-1: rdAddr<=0 and pass<=1 (the second copy starts).
  - On hsFall: rdAddr<=0 and pass<=0. This takes priority over the lineLen wrap in the same cycle.
  - When rdAddr reaches lineLen-1 with pass=1, it wraps to 0 and pass stays 1 (third copy). This only happens if the input line is longer than lineLen, and is allowed.
- **Output pipeline (2-clock latency from rdAddr to rgbOut):**
  - Stage 1: registered buffer read.
  - Stage 2: rgbOut<=pixel, with hsync and pass delayed to match.
  - Dimming: if scanlines=1 and pass=1, each 3-bit channel is shifted right by one (7->3, 4->2, 1->0). Otherwise the pixel passes unchanged.
- **Output sync:**
  - hsRaw = (rdAddr < HS_WIDTH) ? 0 : 1.
  - hsOut is hsRaw delayed 2 clocks, so it stays aligned with pixels.
  - vsOut<=vsIn (last sampled value), updated only when rdAddr==0; it is delayed by the same 2 clocks. vsync edges therefore coincide with output line starts.
- **Line timing:** nominal input line = 448 pixels = 896 clocks. Output = 2 lines of 448 clocks each, 31.25 kHz.
- **Simultaneous events:**
  - hsFall on the same clock as the rdAddr wrap: hsFall wins.
  - hsFall while wrAddr is saturated: normal handling; lineLen<=DEPTH-1.
- **Bank handling:** bank swap and read-bank select change on the same clock. Read and write never address the same bank except during the first line after reset, when the output is undefined but finite.

Test Plan:
- **Reset values:** hold reset=0 mid-stream -> rgbOut=0, hsOut=1, vsOut=1 immediately (asynchronous). After release and before the first hsFall, lineLen=448.
- **Nominal doubling:** 448-pixel lines, pixel n = n[8:0], hsIn low for 32 pixels.
  - Each line is reproduced twice, 448 clocks apart.
  - rgbOut at 2 clocks after rdAddr=k equals k.
  - Exactly two hsOut pulses of 54 clocks each per input line.
- **Scanline dimming:** constant input 9'h1FF with scanlines=1 -> first copy 9'h1FF, second copy 9'h0DB (3,3,3). With scanlines=0 both copies are 9'h1FF.
- **Glitch reject:** insert a spurious hsIn low after 40 pixels -> lineLen stays 448, and the output line period remains 448 clocks after the next valid line.
- **Long line saturation:** a 600-pixel line -> wrAddr saturates at 511, lineLen=511, and addresses 0..510 read back correctly.
- **Vsync alignment:** vsIn falls mid-line -> vsOut falls exactly when the output pixel at rdAddr=0 appears, never mid-line; it stays low for 2× the input vsync line count.

Source files
------------

// File: rtl/zx_scandoubler.sv
// Line-doubling scan converter: buffers one 15.6 kHz input line per bank and
// replays the previous line twice at 31.2 kHz with regenerated hsync.
module zx_scandoubler #(
    parameter int DEPTH        = 512,
    parameter int LINE_DEFAULT = 448,
    parameter int LINE_MIN     = 64,
    parameter int HS_WIDTH     = 54
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [8:0] rgbIn,
    input  logic       hsIn,
    input  logic       vsIn,
    input  logic       scanlines,
    output logic [8:0] rgbOut,
    output logic       hsOut,
    output logic       vsOut
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] addr_t;
    localparam addr_t ADDR_MAX = addr_t'(DEPTH - 1);

    function automatic logic [8:0] dim(input logic [8:0] p);
        return {1'b0, p[8:7], 1'b0, p[5:4], 1'b0, p[2:1]};
    endfunction

    logic [8:0] mem [2*DEPTH];

    addr_t      wr_addr_q, wr_addr_d;
    addr_t      rd_addr_q, rd_addr_d;
    addr_t      line_len_q, line_len_d;
    logic       bank_q, bank_d;
    logic       pass_q, pass_d;
    logic       hs_prev_q, hs_prev_d;
    logic       vs_smp_q, vs_smp_d;
    logic       vs_line_q, vs_line_d;
    logic       valid_q, valid_d;

    logic [8:0] pix1_q;
    logic       hs1_q, vs1_q, pass1_q, valid1_q;

    logic       hs_fall;
    addr_t      wr_sel;
    logic       wr_bank;
    logic       hs_raw;
    logic [8:0] rgb_d;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can
        // leave it unassigned and infer a latch.
        wr_addr_d  = wr_addr_q;
        line_len_d = line_len_q;
        bank_d     = bank_q;
        rd_addr_d  = rd_addr_q + addr_t'(1);
        pass_d     = pass_q;

        hs_fall    = ce & hs_prev_q & ~hsIn;
        hs_prev_d  = ce ? hsIn : hs_prev_q;
        vs_smp_d   = ce ? vsIn : vs_smp_q;
        valid_d    = valid_q | hs_fall;

        // The pixel that carries the sync edge opens the new line at address 0.
        wr_sel  = hs_fall ? '0 : wr_addr_q;
        wr_bank = hs_fall ? ~bank_q : bank_q;

        if (hs_fall) begin
            wr_addr_d = addr_t'(1);
            bank_d    = ~bank_q;
            if (wr_addr_q >= addr_t'(LINE_MIN))
                line_len_d = wr_addr_q;
        end else if (ce && wr_addr_q != ADDR_MAX) begin
            wr_addr_d = wr_addr_q + addr_t'(1);
        end

        if (hs_fall) begin
            rd_addr_d = '0;
            pass_d    = 1'b0;
        end else if (rd_addr_q == line_len_q - addr_t'(1)) begin
            rd_addr_d = '0;
            pass_d    = 1'b1;
        end

        hs_raw    = (rd_addr_q >= addr_t'(HS_WIDTH));
        vs_line_d = (rd_addr_q == '0) ? vs_smp_q : vs_line_q;

        if (!valid1_q)
            rgb_d = '0;
        else if (scanlines && pass1_q)
            rgb_d = dim(pix1_q);
        else
            rgb_d = pix1_q;
    end

    // NOTE: the line buffer has no reset so it maps onto block RAM; stale
    // contents are hidden by the valid flag until a fresh line is written.
    always_ff @(posedge clock) begin
        if (ce)
            mem[{wr_bank, wr_sel}] <= rgbIn;
        pix1_q <= mem[{~bank_q, rd_addr_q}];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            line_len_q <= addr_t'(LINE_DEFAULT);
            bank_q     <= 1'b0;
            pass_q     <= 1'b0;
            hs_prev_q  <= 1'b1;
            vs_smp_q   <= 1'b1;
            vs_line_q  <= 1'b1;
            valid_q    <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            pass1_q    <= 1'b0;
            valid1_q   <= 1'b0;
            rgbOut     <= '0;
            hsOut      <= 1'b1;
            vsOut      <= 1'b1;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            line_len_q <= line_len_d;
            bank_q     <= bank_d;
            pass_q     <= pass_d;
            hs_prev_q  <= hs_prev_d;
            vs_smp_q   <= vs_smp_d;
            vs_line_q  <= vs_line_d;
            valid_q    <= valid_d;
            // Stage 1 travels alongside the registered buffer read.
            hs1_q      <= hs_raw;
            vs1_q      <= vs_line_d;
            pass1_q    <= pass_q;
            valid1_q   <= valid_q;
            rgbOut     <= rgb_d;
            hsOut      <= hs1_q;
            vsOut      <= vs1_q;
        end
    end

endmodule

// File: tb/tb_zx_scandoubler.sv
// Directed bench for zx_scandoubler: streams hand-built lines, logs every
// output cycle, then checks doubled lines, dimming, sync timing and reset.
`timescale 1ns/1ps
module tb_zx_scandoubler;

    localparam int LOGN = 32768;

    logic       clock = 1'b0;
    logic       reset;
    logic       ce;
    logic [8:0] rgbIn;
    logic       hsIn;
    logic       vsIn;
    logic       scanlines;
    logic [8:0] rgbOut;
    logic       hsOut;
    logic       vsOut;

    logic [8:0] rgb_log [LOGN];
    logic       hs_log  [LOGN];
    logic       vs_log  [LOGN];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    zx_scandoubler dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .rgbIn    (rgbIn),
        .hsIn     (hsIn),
        .vsIn     (vsIn),
        .scanlines(scanlines),
        .rgbOut   (rgbOut),
        .hsOut    (hsOut),
        .vsOut    (vsOut)
    );

    always #36 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, log outputs 1 ns later.
    task automatic step(input logic ce_v, input logic [8:0] rgb_v, input logic hs_v,
                        input logic vs_v, input logic sc_v);
        ce = ce_v; rgbIn = rgb_v; hsIn = hs_v; vsIn = vs_v; scanlines = sc_v;
        @(posedge clock);
        #1;
        if (cyc < LOGN) begin
            rgb_log[cyc] = rgbOut;
            hs_log[cyc]  = hsOut;
            vs_log[cyc]  = vsOut;
        end
        cyc++;
    endtask

    task automatic pix(input logic [8:0] rgb_v, input logic hs_v, input logic vs_v, input logic sc_v);
        step(1'b1, rgb_v, hs_v, vs_v, sc_v);
        step(1'b0, rgb_v, hs_v, vs_v, sc_v);
    endtask

    task automatic send_line(input int len, input int hs_len, input bit solid, input logic vs0,
                             input int vs_sw, input logic sc, output int start);
        start = cyc;
        for (int n = 0; n < len; n++)
            pix(solid ? 9'h1FF : 9'(n), (n < hs_len) ? 1'b0 : 1'b1,
                (n < vs_sw) ? vs0 : ~vs0, sc);
    endtask

    function automatic int bad_seq(input int base, input int n, input int first);
        int b = 0;
        for (int k = 0; k < n; k++)
            if (rgb_log[base+k] !== 9'(first + k)) b++;
        return b;
    endfunction

    function automatic int bad_const(input int base, input int n, input logic [8:0] val);
        int b = 0;
        for (int k = 0; k < n; k++)
            if (rgb_log[base+k] !== val) b++;
        return b;
    endfunction

    function automatic int hs_lows(input int base, input int n);
        int c = 0;
        for (int k = 0; k < n; k++)
            if (hs_log[base+k] === 1'b0) c++;
        return c;
    endfunction

    function automatic int hs_falls(input int base, input int n);
        int c = 0;
        for (int k = 0; k < n; k++)
            if (hs_log[base+k-1] === 1'b1 && hs_log[base+k] === 1'b0) c++;
        return c;
    endfunction

    function automatic int vs_lows(input int base, input int n);
        int c = 0;
        for (int k = 0; k < n; k++)
            if (vs_log[base+k] === 1'b0) c++;
        return c;
    endfunction

    initial begin
        int rel, rel2, h, tmp;
        int e [4];
        int s [4];
        int ev [4];
        int n0, sh, g, v, w, lg, p, q, r0, r1;

        reset = 1'b0; ce = 1'b0; rgbIn = '0; hsIn = 1'b1; vsIn = 1'b1; scanlines = 1'b0;

        // Reset state.
        for (int i = 0; i < 4; i++) pix(9'h000, 1'b1, 1'b1, 1'b0);
        check("reset_rgb", rgbOut, 9'h000);
        check("reset_hs", hsOut, 1'b1);
        check("reset_vs", vsOut, 1'b1);

        // Free-running output before any input sync: default 448-clock lines.
        reset = 1'b1;
        rel = cyc;
        for (int i = 0; i < 500; i++) pix(9'h155, 1'b1, 1'b1, 1'b0);
        check("idle_hs_pre", hs_log[rel], 1'b1);
        check("idle_hs_fall", hs_log[rel+1], 1'b0);
        check("idle_hs_last_low", hs_log[rel+54], 1'b0);
        check("idle_hs_rise", hs_log[rel+55], 1'b1);
        check("idle_period_pre", hs_log[rel+448], 1'b1);
        check("idle_period_fall", hs_log[rel+449], 1'b0);
        check("idle_blank", bad_const(rel, 1000, 9'h000), 0);

        // Nominal doubling.
        for (int i = 0; i < 4; i++) send_line(448, 32, 1'b0, 1'b1, 9999, 1'b0, e[i]);

        // Scanline dimming.
        send_line(448, 32, 1'b1, 1'b1, 9999, 1'b0, s[0]);
        send_line(448, 32, 1'b1, 1'b1, 9999, 1'b1, s[1]);
        send_line(448, 32, 1'b1, 1'b1, 9999, 1'b0, s[2]);
        send_line(448, 32, 1'b1, 1'b1, 9999, 1'b0, s[3]);

        // Glitch: short 40-pixel segment ended by a spurious sync.
        send_line(448, 32, 1'b0, 1'b1, 9999, 1'b0, n0);
        send_line(40,  32, 1'b0, 1'b1, 9999, 1'b0, sh);
        send_line(448, 4,  1'b0, 1'b1, 9999, 1'b0, g);
        send_line(448, 32, 1'b0, 1'b1, 9999, 1'b0, v);
        send_line(448, 32, 1'b0, 1'b1, 9999, 1'b0, w);

        // Long line saturating the write address.
        send_line(600, 32, 1'b0, 1'b1, 9999, 1'b0, lg);
        send_line(448, 32, 1'b0, 1'b1, 9999, 1'b0, p);
        send_line(448, 32, 1'b0, 1'b1, 9999, 1'b0, q);

        // Vsync low from pixel 200 of ev[0] to pixel 200 of ev[2].
        send_line(448, 32, 1'b0, 1'b1, 200,  1'b0, ev[0]);
        send_line(448, 32, 1'b0, 1'b0, 9999, 1'b0, ev[1]);
        send_line(448, 32, 1'b0, 1'b0, 200,  1'b0, ev[2]);
        send_line(448, 32, 1'b0, 1'b1, 9999, 1'b0, ev[3]);

        // Mid-line reset while vsync is low and output hsync is active.
        send_line(448, 32, 1'b0, 1'b0, 9999, 1'b0, r0);
        r1 = cyc;
        for (int n = 0; n <= 10; n++) pix(9'(n), (n < 4) ? 1'b0 : 1'b1, 1'b0, 1'b0);
        check("pre_reset_rgb", rgbOut, 9'd19);
        check("pre_reset_hs", hsOut, 1'b0);
        check("pre_reset_vs", vsOut, 1'b0);
        reset = 1'b0;
        #1;
        check("async_reset_rgb", rgbOut, 9'h000);
        check("async_reset_hs", hsOut, 1'b1);
        check("async_reset_vs", vsOut, 1'b1);
        for (int n = 11; n <= 12; n++) pix(9'(n), 1'b1, 1'b0, 1'b0);
        check("held_reset_rgb", rgbOut, 9'h000);
        reset = 1'b1;
        rel2 = cyc;
        for (int n = 13; n < 448; n++) pix(9'(n), 1'b1, 1'b0, 1'b0);
        send_line(448, 32, 1'b0, 1'b1, 9999, 1'b0, h);

        // Nominal doubling: line e[1] replayed after e[2], twice.
        check("nom_copy1", bad_seq(e[2] + 2, 448, 0), 0);
        check("nom_copy2", bad_seq(e[2] + 450, 448, 0), 0);
        check("nom_next_copy1", bad_seq(e[3] + 2, 448, 0), 0);
        check("nom_hs_low_clocks", hs_lows(e[2] + 2, 896), 108);
        check("nom_hs_pulses", hs_falls(e[2] + 2, 896), 2);
        check("nom_hs_last_low", hs_log[e[2] + 55], 1'b0);
        check("nom_hs_rise", hs_log[e[2] + 56], 1'b1);

        // Dimmed second copy only while scanlines=1.
        check("dim_copy1", bad_const(s[1] + 2, 448, 9'h1FF), 0);
        check("dim_copy2", bad_const(s[1] + 450, 446, 9'h0DB), 0);
        check("nodim_copy1", bad_const(s[2] + 2, 448, 9'h1FF), 0);
        check("nodim_copy2", bad_const(s[2] + 450, 448, 9'h1FF), 0);

        // Glitch rejected: line length stays 448.
        check("glitch_hs_pulses", hs_falls(g + 2, 896), 2);
        check("glitch_after_copy1", bad_seq(v + 2, 448, 0), 0);
        check("glitch_after_copy2", bad_seq(v + 450, 448, 0), 0);
        check("glitch_period_pre", hs_log[v + 449], 1'b1);
        check("glitch_period_fall", hs_log[v + 450], 1'b0);

        // Saturated line: 511 entries replayed, period 511.
        check("long_copy1", bad_seq(p + 2, 511, 0), 0);
        check("long_wrap_pre", hs_log[p + 512], 1'b1);
        check("long_wrap_fall", hs_log[p + 513], 1'b0);
        check("long_copy2", bad_seq(p + 513, 385, 0), 0);

        // Vsync moves only on output line starts; 2 input lines -> 4 output lines.
        check("vs_fall_pre", vs_log[ev[0] + 449], 1'b1);
        check("vs_fall", vs_log[ev[0] + 450], 1'b0);
        check("vs_rise_pre", vs_log[ev[2] + 449], 1'b0);
        check("vs_rise", vs_log[ev[2] + 450], 1'b1);
        check("vs_low_clocks", vs_lows(ev[0], 2392), 1792);

        // After the mid-line reset: black until the sync edge, then fresh data.
        tmp = h + 2 - rel2;
        check("post_reset_blank", bad_const(rel2, tmp, 9'h000), 0);
        check("post_reset_line", bad_seq(h + 2, 435, 13), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
